// File: rtl/buf_collector_pkg.sv
// Shared types and constants for the per-core result buffer collector.
package buf_collector_pkg;
    localparam int          N_CORES_DEF = 4;
    localparam logic [31:0] SAD_INIT    = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/buf_collector_if.sv
// Core-side buffer bus plus result outputs; master = cores/board, slave = collector.
interface buf_collector_if import buf_collector_pkg::*; #(
    parameter int N_CORES = N_CORES_DEF,
    parameter int IDX_W   = 2
);
    logic                   clear;
    logic [N_CORES-1:0]     core_en;
    logic [N_CORES-1:0]     buf_flag;
    logic [32*N_CORES-1:0]  buf_val_1_bus;
    logic [32*N_CORES-1:0]  buf_val_2_bus;
    logic [N_CORES-1:0]     captured;
    logic                   busy;
    logic                   done;
    logic                   best_valid;
    logic [31:0]            best_sad;
    logic [31:0]            best_coord;
    logic [IDX_W-1:0]       best_core;

    modport master (
        output clear, core_en, buf_flag, buf_val_1_bus, buf_val_2_bus,
        input  captured, busy, done, best_valid, best_sad, best_coord, best_core
    );

    modport slave (
        input  clear, core_en, buf_flag, buf_val_1_bus, buf_val_2_bus,
        output captured, busy, done, best_valid, best_sad, best_coord, best_core
    );
endinterface

// File: rtl/buf_capture_slot.sv
// One core's record slot: flag rise detect, first-record-wins capture of SAD/coord.
module buf_capture_slot (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        clear,
    input  logic        accept_en,
    input  logic        buf_flag,
    input  logic [31:0] val_1,
    input  logic [31:0] val_2,
    output logic        captured,
    output logic [31:0] sad,
    output logic [31:0] coord
);
    logic flag_d;
    logic take;

    // flag_d is deliberately untouched by clear so a held flag is not re-captured.
    assign take = buf_flag & ~flag_d & ~captured & accept_en & ~clear;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) flag_d <= 1'b0;
        else       flag_d <= buf_flag;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)      captured <= 1'b0;
        else if (clear) captured <= 1'b0;
        else if (take)  captured <= 1'b1;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sad   <= '0;
            coord <= '0;
        end else if (take) begin
            sad   <= val_1;
            coord <= val_2;
        end
    end
endmodule

// File: rtl/buf_collector.sv
// Collects one SAD/coord record per enabled core, then serially scans for the minimum SAD.
module buf_collector import buf_collector_pkg::*; #(
    parameter int N_CORES = N_CORES_DEF,
    parameter int IDX_W   = 2
) (
    input logic            Clk,
    input logic            Reset,
    buf_collector_if.slave bus
);
    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [N_CORES-1:0] captured;
    logic [31:0]        slot_sad   [N_CORES];
    logic [31:0]        slot_coord [N_CORES];
    logic               complete;
    logic               accept_en;
    logic               scan_start;
    logic               last_idx;
    logic [31:0]        best_sad, best_coord;
    logic [IDX_W-1:0]   best_core;
    logic               best_valid;

    for (genvar g = 0; g < N_CORES; g++) begin : g_slot
        buf_capture_slot u_slot (
            .Clk       (Clk),
            .Reset     (Reset),
            .clear     (bus.clear),
            .accept_en (accept_en),
            .buf_flag  (bus.buf_flag[g]),
            .val_1     (bus.buf_val_1_bus[32*g +: 32]),
            .val_2     (bus.buf_val_2_bus[32*g +: 32]),
            .captured  (captured[g]),
            .sad       (slot_sad[g]),
            .coord     (slot_coord[g])
        );
    end

    assign complete   = &(captured | ~bus.core_en);
    assign accept_en  = (state != DONE);
    assign last_idx   = (idx == IDX_W'(N_CORES - 1));
    assign scan_start = (state_nxt == SCAN) && (state != SCAN);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // IDLE skips WAIT when every enabled core has already reported.
    always_comb begin
        state_nxt = state;
        if (bus.clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (complete) state_nxt = SCAN;
                      else if (|captured) state_nxt = WAIT;
                WAIT: if (complete) state_nxt = SCAN;
                SCAN: if (last_idx) state_nxt = DONE;
                DONE: state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            WAIT, SCAN: bus.busy = 1'b1;
            DONE:       bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                        idx <= '0;
        else if (bus.clear || state != SCAN) idx <= '0;
        else                              idx <= idx + IDX_W'(1);
    end

    // Strict less-than keeps the lower index on equal SADs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            best_sad   <= SAD_INIT;
            best_coord <= '0;
            best_core  <= '0;
            best_valid <= 1'b0;
        end else if (bus.clear || scan_start) begin
            best_sad   <= SAD_INIT;
            best_coord <= '0;
            best_core  <= '0;
            best_valid <= 1'b0;
        end else if (state == SCAN && bus.core_en[idx]) begin
            best_valid <= 1'b1;
            if (slot_sad[idx] < best_sad) begin
                best_sad   <= slot_sad[idx];
                best_coord <= slot_coord[idx];
                best_core  <= idx;
            end
        end
    end

    assign bus.captured   = captured;
    assign bus.best_sad   = best_sad;
    assign bus.best_coord = best_coord;
    assign bus.best_core  = best_core;
    assign bus.best_valid = best_valid;
endmodule
